// File: rtl/ublock_ti_pkg.sv
// Shared definitions for the masked uBlock key path: default sizes, the
// round-key store FSM states and the two-share key container.
package ublock_ti_pkg;

    localparam int DEF_NUM_RK = 17;
    localparam int DEF_KEY_W  = 128;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } rk_state_e;

    typedef struct packed {
        logic [DEF_KEY_W-1:0] share0;
        logic [DEF_KEY_W-1:0] share1;
    } shared_key_t;

endpackage

// File: rtl/shared_rk_bank.sv
// Two-share round-key register bank: one write port, one registered read port.
// Share 0 and share 1 live in separate arrays so they never meet in a mux.
module shared_rk_bank #(
    parameter int NUM_RK = 17,
    parameter int KEY_W  = 128,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_share0,
    input  logic [KEY_W-1:0] wr_share1,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_share0,
    output logic [KEY_W-1:0] rd_share1,
    output logic             rd_valid
);

    localparam logic [31:0] NUM_RK_U = 32'(NUM_RK);

    logic [KEY_W-1:0] bank0 [NUM_RK];
    logic [KEY_W-1:0] bank1 [NUM_RK];
    logic             rd_in_range;

    assign rd_in_range = 32'(rd_idx) < NUM_RK_U;

    // NOTE: the bank is reset explicitly so no key material from a previous
    // session can be read back after reset; this costs flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RK; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_en) begin
            bank0[wr_idx] <= wr_share0;
            bank1[wr_idx] <= wr_share1;
        end
    end

    // Reads sample the pre-write content, so a same-index read/write returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_share0 <= '0;
            rd_share1 <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_in_range) begin
                    rd_share0 <= bank0[rd_idx];
                    rd_share1 <= bank1[rd_idx];
                end else begin
                    rd_share0 <= '0;
                    rd_share1 <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/shared_round_key_store.sv
// Sequences shared_key_expansion once per master key and serves the captured
// two-share round keys by index. Optional remask: define SHARED_RK_REFRESH_EN.
module shared_round_key_store
    import ublock_ti_pkg::*;
#(
    parameter int NUM_RK = DEF_NUM_RK,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             rk_ready,
    output logic             key_exp_ena,
    output logic [CNT_W-1:0] key_exp_round_cnt,
    input  logic [KEY_W-1:0] full_round_key0,
    input  logic [KEY_W-1:0] full_round_key1,
`ifdef SHARED_RK_REFRESH_EN
    input  logic [KEY_W-1:0] rnd,
`endif
    input  logic             rd_en,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key0,
    output logic [KEY_W-1:0] rd_key1,
    output logic             rd_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_RK - 1);

    rk_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [KEY_W-1:0] wr_share0, wr_share1;

    // NOTE: state registers use non-blocking assignments; the combinational
    // block below uses blocking ones and assigns defaults first so no latch forms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, READY: begin
                if (start) begin
                    state_nxt = EXPAND;
                    cnt_nxt   = '0;
                end
            end
            EXPAND: begin
                // start is deliberately not looked at here: an expansion always completes.
                if (cnt == CNT_LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy              = (state == EXPAND);
    assign rk_ready          = (state == READY);
    assign key_exp_ena       = busy;
    assign key_exp_round_cnt = busy ? cnt : '0;

`ifdef SHARED_RK_REFRESH_EN
    // The same mask on both shares keeps the share sum while refreshing each share.
    assign wr_share0 = full_round_key0 ^ rnd;
    assign wr_share1 = full_round_key1 ^ rnd;
`else
    assign wr_share0 = full_round_key0;
    assign wr_share1 = full_round_key1;
`endif

    shared_rk_bank #(
        .NUM_RK (NUM_RK),
        .KEY_W  (KEY_W),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (busy),
        .wr_idx    (cnt),
        .wr_share0 (wr_share0),
        .wr_share1 (wr_share1),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_share0 (rd_key0),
        .rd_share1 (rd_key1),
        .rd_valid  (rd_valid)
    );

endmodule

// File: tb/tb_shared_round_key_store.sv
// Directed bench for shared_round_key_store; a stand-in expansion block
// produces round key i as shares {golden(i) ^ mask(i), mask(i)}.
module tb_shared_round_key_store;

    localparam int NUM_RK = 17;
    localparam int KEY_W  = 128;
    localparam int CNT_W  = 5;
    localparam logic [KEY_W-1:0] MK      = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [KEY_W-1:0] ALL_ONE = {KEY_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, rk_ready, key_exp_ena, rd_valid;
    logic [CNT_W-1:0] key_exp_round_cnt;
    logic [KEY_W-1:0] full_round_key0, full_round_key1;
    logic             rd_en = 1'b0;
    logic [CNT_W-1:0] rd_idx = '0;
    logic [KEY_W-1:0] rd_key0, rd_key1;
`ifdef SHARED_RK_REFRESH_EN
    logic [KEY_W-1:0] rnd = ALL_ONE;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shared_round_key_store #(
        .NUM_RK (NUM_RK),
        .KEY_W  (KEY_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .rk_ready          (rk_ready),
        .key_exp_ena       (key_exp_ena),
        .key_exp_round_cnt (key_exp_round_cnt),
        .full_round_key0   (full_round_key0),
        .full_round_key1   (full_round_key1),
`ifdef SHARED_RK_REFRESH_EN
        .rnd               (rnd),
`endif
        .rd_en             (rd_en),
        .rd_idx            (rd_idx),
        .rd_key0           (rd_key0),
        .rd_key1           (rd_key1),
        .rd_valid          (rd_valid)
    );

    // Stand-in key schedule: round i is the master key rotated left by i bytes.
    function automatic logic [KEY_W-1:0] golden(input int i);
        logic [KEY_W-1:0] v;
        v = MK;
        for (int k = 0; k < i; k++) v = {v[KEY_W-9:0], v[KEY_W-1 -: 8]};
        return v;
    endfunction

    function automatic logic [KEY_W-1:0] mask(input int i);
        logic [7:0] b;
        b = 8'(i * 37);
        return {16{b}};
    endfunction

    function automatic logic [KEY_W-1:0] stored0(input int i);
`ifdef SHARED_RK_REFRESH_EN
        return golden(i) ^ mask(i) ^ ALL_ONE;
`else
        return golden(i) ^ mask(i);
`endif
    endfunction

    function automatic logic [KEY_W-1:0] stored1(input int i);
`ifdef SHARED_RK_REFRESH_EN
        return mask(i) ^ ALL_ONE;
`else
        return mask(i);
`endif
    endfunction

    assign full_round_key0 = golden(int'(key_exp_round_cnt)) ^ mask(int'(key_exp_round_cnt));
    assign full_round_key1 = mask(int'(key_exp_round_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one expansion from start; optionally pulses start again at step
    // restart_at and issues a same-index read at step probe_idx.
    task automatic run_expansion(input int restart_at, input int probe_idx,
                                 input logic [KEY_W-1:0] probe0, input logic [KEY_W-1:0] probe1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NUM_RK; i++) begin
            n_vec++;
            if ({busy, key_exp_ena, rk_ready, key_exp_round_cnt} !== {1'b1, 1'b1, 1'b0, 5'(i)}) begin
                n_err++;
                $display("FAIL expand_step%0d: busy/ena/rdy/cnt got %b%b%b/%0d want 110/%0d",
                         i, busy, key_exp_ena, rk_ready, key_exp_round_cnt, i);
            end
            start  = (i == restart_at);
            rd_en  = (i == probe_idx);
            rd_idx = 5'(i);
            tick();
            start = 1'b0;
            if (i == probe_idx) begin
                rd_en = 1'b0;
                n_vec++;
                if ({rd_valid, rd_key0, rd_key1} !== {1'b1, probe0, probe1}) begin
                    n_err++;
                    $display("FAIL same_idx_rw%0d: got v=%b k0=%h k1=%h want v=1 k0=%h k1=%h",
                             i, rd_valid, rd_key0, rd_key1, probe0, probe1);
                end
            end
        end
        n_vec++;
        if ({busy, key_exp_ena, rk_ready, key_exp_round_cnt} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL expand_done: busy/ena/rdy/cnt got %b%b%b/%0d want 001/0",
                     busy, key_exp_ena, rk_ready, key_exp_round_cnt);
        end
    endtask

    // Back-to-back reads of every index; checks stored shares and share sum.
    task automatic read_all(input string tag);
        rd_en = 1'b1;
        for (int i = 0; i < NUM_RK; i++) begin
            rd_idx = 5'(i);
            tick();
            n_vec++;
            if ({rd_valid, rd_key0, rd_key1} !== {1'b1, stored0(i), stored1(i)}) begin
                n_err++;
                $display("FAIL %s_rd%0d: got v=%b k0=%h k1=%h want v=1 k0=%h k1=%h",
                         tag, i, rd_valid, rd_key0, rd_key1, stored0(i), stored1(i));
            end
            n_vec++;
            if ((rd_key0 ^ rd_key1) !== golden(i)) begin
                n_err++;
                $display("FAIL %s_sum%0d: got %h want %h", tag, i, rd_key0 ^ rd_key1, golden(i));
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({busy, rk_ready, key_exp_ena, rd_valid, key_exp_round_cnt, rd_key0, rd_key1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b rdy=%b ena=%b v=%b cnt=%0d k0=%h k1=%h want all 0",
                     busy, rk_ready, key_exp_ena, rd_valid, key_exp_round_cnt, rd_key0, rd_key1);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if ({busy, rk_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: busy/rdy got %b%b want 00", busy, rk_ready);
        end
    endtask

    task automatic test_expansion();
        run_expansion(-1, 3, '0, '0);
        read_all("expand");
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({busy, rk_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL restart_from_ready: busy/rdy got %b%b want 10", busy, rk_ready);
        end
        // Abandon that run with a reset so run_expansion starts cleanly.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_expansion(5, -1, '0, '0);
        read_all("restart");
    endtask

    task automatic test_reset_mid_expand();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (key_exp_round_cnt !== 5'd8) begin
            n_err++;
            $display("FAIL mid_cnt: got %0d want 8", key_exp_round_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, rk_ready, key_exp_ena, key_exp_round_cnt} !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: busy/rdy/ena/cnt got %b%b%b/%0d want 000/0",
                     busy, rk_ready, key_exp_ena, key_exp_round_cnt);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({busy, rk_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL stay_idle: busy/rdy got %b%b want 00", busy, rk_ready);
        end
        rd_en  = 1'b1;
        rd_idx = 5'd3;
        tick();
        rd_en = 1'b0;
        n_vec++;
        if ({rd_valid, rd_key0, rd_key1} !== {1'b1, {2*KEY_W{1'b0}}}) begin
            n_err++;
            $display("FAIL bank_cleared: got v=%b k0=%h k1=%h want v=1 k0=0 k1=0",
                     rd_valid, rd_key0, rd_key1);
        end
        run_expansion(-1, 7, '0, '0);
        read_all("after_rst");
    endtask

    task automatic test_back_to_back();
        rd_en  = 1'b1;
        rd_idx = 5'd3;
        tick();
        n_vec++;
        if ({rd_valid, rd_key0, rd_key1} !== {1'b1, stored0(3), stored1(3)}) begin
            n_err++;
            $display("FAIL b2b_idx3: got v=%b k0=%h k1=%h want v=1 k0=%h k1=%h",
                     rd_valid, rd_key0, rd_key1, stored0(3), stored1(3));
        end
        rd_idx = 5'd4;
        tick();
        n_vec++;
        if ({rd_valid, rd_key0, rd_key1} !== {1'b1, stored0(4), stored1(4)}) begin
            n_err++;
            $display("FAIL b2b_idx4: got v=%b k0=%h k1=%h want v=1 k0=%h k1=%h",
                     rd_valid, rd_key0, rd_key1, stored0(4), stored1(4));
        end
        rd_idx = 5'd20;
        tick();
        n_vec++;
        if ({rd_valid, rd_key0, rd_key1} !== {1'b1, {2*KEY_W{1'b0}}}) begin
            n_err++;
            $display("FAIL out_of_range: got v=%b k0=%h k1=%h want v=1 k0=0 k1=0",
                     rd_valid, rd_key0, rd_key1);
        end
        rd_idx = 5'd17;
        tick();
        n_vec++;
        if ({rd_valid, rd_key0, rd_key1} !== {1'b1, {2*KEY_W{1'b0}}}) begin
            n_err++;
            $display("FAIL idx_num_rk: got v=%b k0=%h k1=%h want v=1 k0=0 k1=0",
                     rd_valid, rd_key0, rd_key1);
        end
        rd_en  = 1'b0;
        rd_idx = 5'd16;
        tick();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: got %b want 0", rd_valid);
        end
        n_vec++;
        if (rk_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_held: got %b want 1", rk_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_expansion();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_expand();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shared_round_key_store.md
# shared_round_key_store

Downstream consumer of `shared_key_expansion`. It sequences the expansion by driving `key_exp_ena` and `key_exp_round_cnt`, and captures every two-share round key into an indexed register bank. It then serves the keys by index to the masked uBlock round datapath, so expansion runs once per master key rather than once per block.

## Interface
Parameters:
- `NUM_RK`, default 17: round keys stored (indices 0..NUM_RK-1); must be at most 32.
- `KEY_W`, default 128: width of each share.
- `CNT_W`, default 5: width of the round counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins expansion of the presented master key.
- `busy`  out  1  high while expansion is in progress.
- `rk_ready`  out  1  high when the bank holds a complete key set.
- `key_exp_ena`  out  1  to the expansion block.
- `key_exp_round_cnt`  out  CNT_W  to the expansion block.
- `full_round_key0`  in  KEY_W  share 0 from the expansion block.
- `full_round_key1`  in  KEY_W  share 1 from the expansion block.
- `rd_en`  in  1  read request.
- `rd_idx`  in  CNT_W  round key index to read.
- `rd_key0`  out  KEY_W  registered share 0.
- `rd_key1`  out  KEY_W  registered share 1.
- `rd_valid`  out  1  read data valid.
- `rnd`  in  KEY_W  fresh randomness; present only with `SHARED_RK_REFRESH_EN`.

## Operation
- FSM states: IDLE, EXPAND, READY.
- IDLE:
  - `start` → EXPAND; `cnt` = 0.
- EXPAND:
  - `key_exp_ena` = 1.
  - `key_exp_round_cnt` = `cnt`.
  - Each cycle, bank[`cnt`] ← {`full_round_key0`, `full_round_key1`}; then `cnt`++.
  - When `cnt` == NUM_RK-1, that entry is written and the FSM goes to READY.
- READY:
  - `rk_ready` = 1; `key_exp_ena` = 0; `key_exp_round_cnt` = 0.
  - `start` → EXPAND with `cnt` = 0; `rk_ready` drops on the next cycle.
- `start` during EXPAND is ignored. The expansion is not restarted.
- Reads:
  - `rd_en` with `rd_idx` < NUM_RK → `rd_key*` ← bank[`rd_idx`] and `rd_valid` = 1, both one cycle later.
  - `rd_idx` ≥ NUM_RK → `rd_key*` = 0 and `rd_valid` = 1.
  - A read while `rk_ready` = 0 returns whatever the bank holds. Gating reads is the caller's responsibility.
- Shares are never recombined. Share 0 and share 1 travel on independent register and mux paths.
- Counter arithmetic is unsigned CNT_W. No wrap occurs, because the terminal compare fires at NUM_RK-1.

## Timing
- Reset values:
  - `busy`, `rk_ready`, `key_exp_ena`, `rd_valid` = 0.
  - `key_exp_round_cnt` = 0; `rd_key*` = 0.
  - Bank = 0; FSM = IDLE.
- Expansion latency: `start` at cycle t → `busy` at t+1 → last write at t+NUM_RK → `rk_ready` at t+NUM_RK+1.
- `busy` equals (state == EXPAND).
- The bank is captured on the same edge that advances the expansion block's internal register. Round key i is valid combinationally while `key_exp_round_cnt` == i.
- Read latency is 1 cycle and fully pipelined: a read may be issued every cycle.
- A read and a write to the same index in the same cycle returns the old content.
- Reset mid-EXPAND: all state clears asynchronously, `rk_ready` stays 0, and a new `start` is required.

## Configuration
- `SHARED_RK_REFRESH_EN` defined:
  - Port `rnd` exists.
  - Each captured entry is stored as {`full_round_key0` ^ `rnd`, `full_round_key1` ^ `rnd`}, giving a fresh remask per round key.
  - The stored share sum is unchanged.
- Not defined:
  - No `rnd` port.
  - Shares are stored verbatim.

## Structure
- Shared package `ublock_ti_pkg` holds:
  - `NUM_RK`, `KEY_W`, `CNT_W` defaults;
  - the FSM state enum (IDLE/EXPAND/READY);
  - the `shared_key_t` struct {share0, share1}.
- One natural sub-module: `shared_rk_bank`, a 2-share register bank with a write port and a registered read port. The FSM and counter live in the top level.

## Test plan
- Reset → all outputs 0; `start` at cycle 0 → `key_exp_round_cnt` steps 0..16 over cycles 1..17, `rk_ready` = 1 at cycle 18.
- Master key shares 0x0123…CDEF / 0x0 → read indices 0..16 → share XOR equals the golden uBlock-128/128 key schedule; index 0 = master key.
- `start` asserted again at EXPAND cycle 5 → ignored; count continues to 16 and keys still match golden.
- Assert `rst` at EXPAND cycle 8 → immediate IDLE, `rk_ready` = 0; restart → correct full set.
- `rd_idx` = 20 with `rd_en` → `rd_key*` = 0 and `rd_valid` = 1 next cycle; back-to-back reads of 3 and 4 return bank[3] then bank[4] on consecutive cycles.
- With `SHARED_RK_REFRESH_EN`, `rnd` = 0xFFFF…FFFF → each stored share = input ^ all-ones and share XOR is unchanged.
